// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshakes on both sides, single-cycle ops
// plus iterative unsigned multiply, divide and remainder (one bit per cycle).
module multicycle_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 6
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [OPW-1:0]   ALU_Op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  input  logic             Carry_In,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] RZ,
  output logic [3:0]       Flags,
  output logic             Flag_Write,
  output logic             INR,
  output logic             Busy
);

  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
  localparam logic [OPW-1:0] OP_AND   = OPW'(3);
  localparam logic [OPW-1:0] OP_OR    = OPW'(4);
  localparam logic [OPW-1:0] OP_NEG   = OPW'(5);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(6);
  localparam logic [OPW-1:0] OP_COMP  = OPW'(7);
  localparam logic [OPW-1:0] OP_LSR   = OPW'(8);
  localparam logic [OPW-1:0] OP_ASR   = OPW'(9);
  localparam logic [OPW-1:0] OP_LSL   = OPW'(10);
  localparam logic [OPW-1:0] OP_ROR   = OPW'(11);
  localparam logic [OPW-1:0] OP_ROL   = OPW'(12);
  localparam logic [OPW-1:0] OP_MOVE  = OPW'(13);
  localparam logic [OPW-1:0] OP_PASSB = OPW'(15);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(19);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(20);
  localparam logic [OPW-1:0] OP_REMU  = OPW'(21);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic             cin_q, cin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rz_q, rz_d;
  logic [3:0]       fl_q, fl_d;
  logic             fw_q, fw_d, inr_q, inr_d;

  logic             take, is_iter;
  logic [WIDTH-1:0] sc_rz;
  logic             sc_c, sc_v, sc_fw, sc_inr;
  logic [WIDTH:0]   add_s, sub_s, neg_s;
  logic [WIDTH-1:0] mul_acc, rem_nx, it_rz;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge, it_v;

  assign In_Ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && Out_Ready);
  assign take       = In_Valid && In_Ready;
  assign is_iter    = (ALU_Op == OP_MUL) || (ALU_Op == OP_DIVU) || (ALU_Op == OP_REMU);
  assign Out_Valid  = (state_q == S_DONE);
  assign Busy       = (state_q == S_CALC);
  assign RZ         = rz_q;
  assign Flags      = fl_q;
  assign Flag_Write = fw_q;
  assign INR        = inr_q;

  // Single-cycle datapath, evaluated on the live inputs at the transfer edge.
  always_comb begin
    sc_rz  = '0;
    sc_c   = Carry_In;
    sc_v   = 1'b0;
    sc_fw  = 1'b1;
    sc_inr = 1'b0;
    add_s  = {1'b0, RA} + {1'b0, RB};
    sub_s  = {1'b0, RA} - {1'b0, RB};
    neg_s  = '0 - {1'b0, RA};
    case (ALU_Op)
      OP_NOP:   sc_fw = 1'b0;
      OP_ADD: begin
        sc_rz = add_s[WIDTH-1:0];
        sc_c  = add_s[WIDTH];
        sc_v  = (RA[WIDTH-1] == RB[WIDTH-1]) && (add_s[WIDTH-1] != RA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_rz = sub_s[WIDTH-1:0];
        sc_c  = sub_s[WIDTH];
        sc_v  = (RA[WIDTH-1] != RB[WIDTH-1]) && (sub_s[WIDTH-1] != RA[WIDTH-1]);
      end
      OP_NEG: begin
        sc_rz = neg_s[WIDTH-1:0];
        sc_c  = neg_s[WIDTH];
        sc_v  = RA[WIDTH-1] && neg_s[WIDTH-1];
      end
      OP_AND:   sc_rz = RA & RB;
      OP_OR:    sc_rz = RA | RB;
      OP_XOR:   sc_rz = RA ^ RB;
      OP_COMP:  sc_rz = ~RA;
      OP_LSR: begin
        sc_rz = {1'b0, RA[WIDTH-1:1]};
        sc_c  = RA[0];
      end
      OP_ASR: begin
        sc_rz = {RA[WIDTH-1], RA[WIDTH-1:1]};
        sc_c  = RA[0];
      end
      OP_LSL: begin
        sc_rz = {RA[WIDTH-2:0], 1'b0};
        sc_c  = RA[WIDTH-1];
      end
      OP_ROR: begin
        sc_rz = {Carry_In, RA[WIDTH-1:1]};
        sc_c  = RA[0];
      end
      OP_ROL: begin
        sc_rz = {RA[WIDTH-2:0], Carry_In};
        sc_c  = RA[WIDTH-1];
      end
      OP_MOVE:  sc_rz = RA;
      OP_PASSB: sc_rz = RB;
      OP_MUL, OP_DIVU, OP_REMU: sc_rz = '0;
      default: begin
        sc_fw  = 1'b0;
        sc_inr = 1'b1;
      end
    endcase
  end

  // One iteration step. MUL: a_q multiplier (>>), b_q multiplicand (<<).
  // DIVU/REMU: a_q dividend shifting out MSB-first and collecting quotient bits.
  // A zero divisor naturally yields all-ones quotient and remainder RA.
  always_comb begin
    mul_acc = acc_q + (a_q[0] ? b_q : '0);
    rem_sh  = {acc_q, a_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, b_q});
    rem_nx  = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    it_v    = (op_q != OP_MUL) && (b_q == '0);
    case (op_q)
      OP_MUL:  it_rz = mul_acc;
      OP_DIVU: it_rz = {a_q[WIDTH-2:0], rem_ge};
      default: it_rz = rem_nx;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    rz_d    = rz_q;
    fl_d    = fl_q;
    fw_d    = fw_q;
    inr_d   = inr_q;
    case (state_q)
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          a_d   = a_q >> 1;
          b_d   = b_q << 1;
        end else begin
          acc_d = rem_nx;
          a_d   = {a_q[WIDTH-2:0], rem_ge};
        end
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          rz_d    = it_rz;
          fl_d    = {it_rz[WIDTH-1], it_rz == '0, it_v, cin_q};
          fw_d    = 1'b1;
          inr_d   = 1'b0;
        end
      end
      S_DONE: if (Out_Ready) state_d = S_IDLE;
      default: ;
    endcase
    if (take) begin
      op_d  = ALU_Op;
      cin_d = Carry_In;
      cnt_d = '0;
      if (is_iter) begin
        state_d = S_CALC;
        a_d     = RA;
        b_d     = RB;
        acc_d   = '0;
      end else begin
        state_d = S_DONE;
        rz_d    = sc_rz;
        fl_d    = {sc_rz[WIDTH-1], sc_rz == '0, sc_v, sc_c};
        fw_d    = sc_fw;
        inr_d   = sc_inr;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      rz_q    <= '0;
      fl_q    <= '0;
      fw_q    <= 1'b0;
      inr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      rz_q    <= rz_d;
      fl_q    <= fl_d;
      fw_q    <= fw_d;
      inr_q   <= inr_d;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: reference model with latency tracking,
// per-cycle comparison, and literal expectations from hand calculation.
module tb_multicycle_alu;
  localparam int unsigned W = 32;

  logic        Clock = 1'b0;
  logic        Reset_n, In_Valid, In_Ready, Carry_In, Out_Valid, Out_Ready;
  logic        Flag_Write, INR, Busy;
  logic [5:0]  ALU_Op;
  logic [31:0] RA, RB, RZ;
  logic [3:0]  Flags;

  always #5 Clock = ~Clock;

  multicycle_alu #(.WIDTH(W), .OPW(6)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .ALU_Op(ALU_Op), .RA(RA), .RB(RB), .Carry_In(Carry_In),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .RZ(RZ), .Flags(Flags),
    .Flag_Write(Flag_Write), .INR(INR), .Busy(Busy)
  );

  typedef struct packed {
    logic [31:0] rz;
    logic [3:0]  fl;
    logic        fw;
    logic        inr;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 0;
  res_t m_out, m_pend;
  bit   m_valid, m_fresh;
  int   m_cnt;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin);
    res_t        r;
    longint      sa, sb, s;
    logic [31:0] z;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = '0; c = cin; v = 1'b0; r.fw = 1'b1; r.inr = 1'b0;
    case (op)
      6'd0:  r.fw = 1'b0;
      6'd1:  begin z = a + b; c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF; s = sa + sb;
                   v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd2:  begin z = a - b; c = a < b; s = sa - sb;
                   v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd5:  begin z = 32'd0 - a; c = a != 0; s = -sa;
                   v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd3:  z = a & b;
      6'd4:  z = a | b;
      6'd6:  z = a ^ b;
      6'd7:  z = ~a;
      6'd8:  begin z = a >> 1; c = a[0]; end
      6'd9:  begin z = $signed(a) >>> 1; c = a[0]; end
      6'd10: begin z = a << 1; c = a[31]; end
      6'd11: begin z = {cin, a[31:1]}; c = a[0]; end
      6'd12: begin z = {a[30:0], cin}; c = a[31]; end
      6'd13: z = a;
      6'd15: z = b;
      6'd19: z = a * b;
      6'd20: begin if (b == 0) begin z = '1; v = 1'b1; end else z = a / b; end
      6'd21: begin if (b == 0) begin z = a; v = 1'b1; end else z = a % b; end
      default: begin r.fw = 1'b0; r.inr = 1'b1; end
    endcase
    r.rz = z;
    r.fl = {z[31], z == 0, v, c};
    return r;
  endfunction

  // Transaction-level model: results appear 1 edge after transfer, or W for MUL/DIVU/REMU.
  always @(posedge Clock) begin : model_p
    bit rdy;
    if (!Reset_n) begin
      m_valid = 0; m_cnt = 0; m_out = '0; m_fresh = 1;
    end else begin
      rdy = (m_cnt == 0) && (!m_valid || Out_Ready);
      if (m_valid && Out_Ready) begin m_valid = 0; m_fresh = 0; end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_valid = 1; m_out = m_pend; end
      end
      if (In_Valid && rdy) begin
        if (ALU_Op inside {6'd19, 6'd20, 6'd21}) begin
          m_pend = alu_ref(ALU_Op, RA, RB, Carry_In);
          m_cnt  = W;
        end else begin
          m_out   = alu_ref(ALU_Op, RA, RB, Carry_In);
          m_valid = 1;
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      cmp("out_valid", {31'b0, Out_Valid}, {31'b0, m_valid});
      cmp("busy", {31'b0, Busy}, {31'b0, m_cnt != 0});
      cmp("in_ready", {31'b0, In_Ready}, {31'b0, (m_cnt == 0) && (!m_valid || Out_Ready)});
      if (m_valid || m_fresh) begin
        cmp("rz", RZ, m_out.rz);
        if (m_out.fw) cmp("flags", {28'b0, Flags}, {28'b0, m_out.fl});
        else          cmp("flags_nz", {30'b0, Flags[3:2]}, {30'b0, m_out.fl[3:2]});
        cmp("flag_write", {31'b0, Flag_Write}, {31'b0, m_out.fw});
        cmp("inr", {31'b0, INR}, {31'b0, m_out.inr});
      end
    end
  end

  task automatic xfer(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
    int   n;
    logic rdy;
    ALU_Op = op; RA = a; RB = b; Carry_In = cin; In_Valid = 1'b1;
    n = 0;
    do begin
      @(negedge Clock); rdy = In_Ready;
      @(posedge Clock); n++;
    end while (!rdy && n < 100);
    #2;
    In_Valid = 1'b0; RA = $urandom; RB = $urandom; ALU_Op = 6'($urandom); Carry_In = ~cin;
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL xfer_timeout: got In_Ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin,
                     output res_t got, output int busy_n);
    bit seen;
    xfer(op, a, b, cin);
    busy_n = 0; seen = 0; got = '0;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge Clock);
      if (Out_Valid) begin seen = 1; got = {RZ, Flags, Flag_Write, INR}; end
      else if (Busy) busy_n++;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL result_timeout: got Out_Valid=0 expected 1 within 80 cycles");
    end
    @(posedge Clock); #2;
  endtask

  typedef struct { logic [5:0] op; logic [31:0] a; logic [31:0] b; logic cin; } vec_t;
  vec_t b2b[14] = '{
    '{6'd4,  32'hF0F0_0000, 32'h0000_0F0F, 1'b0}, '{6'd3,  32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1},
    '{6'd6,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0}, '{6'd7,  32'h0000_0000, 32'h1234_5678, 1'b1},
    '{6'd8,  32'h8000_0001, 32'h0,         1'b0}, '{6'd9,  32'h8000_0001, 32'h0,         1'b0},
    '{6'd10, 32'h8000_0001, 32'h0,         1'b0}, '{6'd12, 32'h4000_0000, 32'h0,         1'b1},
    '{6'd13, 32'hDEAD_BEEF, 32'h1,         1'b0}, '{6'd15, 32'h1,         32'hCAFE_F00D, 1'b1},
    '{6'd0,  32'h5,         32'h6,         1'b1}, '{6'd5,  32'h8000_0000, 32'h0,         1'b0},
    '{6'd1,  32'hFFFF_FFFF, 32'h1,         1'b0}, '{6'd2,  32'h8000_0000, 32'h1,         1'b0}
  };

  initial begin
    res_t r;
    int   bn;
    Reset_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    ALU_Op = '0; RA = '0; RB = '0; Carry_In = 1'b0;
    repeat (3) @(posedge Clock);
    #2 Reset_n = 1'b1; chk_en = 1;
    @(negedge Clock);
    cmp("rst_valid", {31'b0, Out_Valid}, 32'd0);
    cmp("rst_rz", RZ, 32'd0);
    cmp("rst_flags", {28'b0, Flags}, 32'd0);
    cmp("rst_fw_inr_busy", {29'b0, Flag_Write, INR, Busy}, 32'd0);
    cmp("rst_ready", {31'b0, In_Ready}, 32'd1);
    @(posedge Clock); #2;

    run(6'd1, 32'h7FFF_FFFF, 32'h1, 1'b0, r, bn);
    cmp("add_rz", r.rz, 32'h8000_0000); cmp("add_flags", {28'b0, r.fl}, 32'hA);
    cmp("add_fw", {31'b0, r.fw}, 32'd1);
    run(6'd2, 32'h0, 32'h1, 1'b0, r, bn);
    cmp("sub_rz", r.rz, 32'hFFFF_FFFF); cmp("sub_flags", {28'b0, r.fl}, 32'h9);
    run(6'd11, 32'h1, 32'h0, 1'b1, r, bn);
    cmp("ror_rz", r.rz, 32'h8000_0000); cmp("ror_flags", {28'b0, r.fl}, 32'h9);
    run(6'd5, 32'h8000_0000, 32'h0, 1'b0, r, bn);
    cmp("neg_min_flags", {28'b0, r.fl}, 32'hB);
    run(6'd19, 32'h0001_0003, 32'h0002_0005, 1'b0, r, bn);
    cmp("mul_rz", r.rz, 32'h000B_000F); cmp("mul_z", {31'b0, r.fl[2]}, 32'd0);
    cmp("mul_busy_cycles", bn, 32'd32);
    run(6'd20, 32'd100, 32'd7, 1'b0, r, bn);
    cmp("divu_rz", r.rz, 32'd14); cmp("divu_busy_cycles", bn, 32'd32);
    run(6'd21, 32'd100, 32'd7, 1'b0, r, bn);
    cmp("remu_rz", r.rz, 32'd2);
    run(6'd20, 32'd5, 32'd0, 1'b0, r, bn);
    cmp("div0_rz", r.rz, 32'hFFFF_FFFF); cmp("div0_flags", {28'b0, r.fl}, 32'hA);
    run(6'd21, 32'd5, 32'd0, 1'b0, r, bn);
    cmp("rem0_rz", r.rz, 32'd5); cmp("rem0_flags", {28'b0, r.fl}, 32'h2);
    run(6'd63, 32'h1234, 32'h5678, 1'b0, r, bn);
    cmp("inr_rz", r.rz, 32'd0); cmp("inr_inr_fw", {30'b0, r.inr, r.fw}, 32'h2);

    foreach (b2b[i]) xfer(b2b[i].op, b2b[i].a, b2b[i].b, b2b[i].cin);
    run(6'd19, 32'd3, 32'd5, 1'b1, r, bn);
    cmp("b2b_mul_rz", r.rz, 32'd15); cmp("b2b_mul_busy", bn, 32'd32);

    Out_Ready = 1'b0;
    xfer(6'd1, 32'h0000_00FF, 32'h1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      cmp("stall_valid", {31'b0, Out_Valid}, 32'd1);
      cmp("stall_rz", RZ, 32'h100);
      cmp("stall_ready", {31'b0, In_Ready}, 32'd0);
      @(posedge Clock); #2;
    end
    Out_Ready = 1'b1;
    xfer(6'd2, 32'd10, 32'd3, 1'b0);
    @(negedge Clock);
    cmp("retire_xfer_rz", RZ, 32'd7); cmp("retire_xfer_valid", {31'b0, Out_Valid}, 32'd1);
    @(posedge Clock); #2;

    xfer(6'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(posedge Clock);
    #2 Reset_n = 1'b0;
    @(posedge Clock);
    #2 Reset_n = 1'b1;
    @(negedge Clock);
    cmp("rst_calc_valid_busy", {30'b0, Out_Valid, Busy}, 32'd0);
    cmp("rst_calc_ready", {31'b0, In_Ready}, 32'd1);
    cmp("rst_calc_rz", RZ, 32'd0);
    @(posedge Clock); #2;
    run(6'd1, 32'd2, 32'd3, 1'b0, r, bn);
    cmp("post_rst_add", r.rz, 32'd5);

    repeat (2) @(posedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
